// File: rtl/unpool_expand_pkg.sv
// Shared helpers for the unpooling stage: counter-width derivation and pipeline latency.
package unpool_expand_pkg;

    // Ceiling log2 with a floor of one bit so single-entry structures still get an address.
    function automatic int log2(input int n);
        int r;
        r = 32'sd1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < n) begin
                r = i + 32'sd1;
            end
        end
        return r;
    endfunction

    function automatic int v_bitw_of(input int w_height);
        return log2(w_height);
    endfunction

    function automatic int h_bitw_of(input int w_width);
        return log2(w_width);
    endfunction

    // One full line plus two pixels: the block value is only known at its bottom-right pixel.
    function automatic int latency_of(input int w_width);
        return w_width + 32'sd2;
    endfunction

endpackage

// File: rtl/coord_adjuster.sv
// Delays the frame line/pixel counters by a fixed number of cycles; wrap-around comes for free.
module coord_adjuster #(
    parameter int V_BITW = 3,
    parameter int H_BITW = 4,
    parameter int DELAY  = 13
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic [V_BITW-1:0] in_vcnt,
    input  logic [H_BITW-1:0] in_hcnt,
    output logic [V_BITW-1:0] out_vcnt,
    output logic [H_BITW-1:0] out_hcnt
);

    logic [V_BITW-1:0] v_pipe_r [DELAY];
    logic [H_BITW-1:0] h_pipe_r [DELAY];

    // Counter shift register, cleared to zero so a fresh start reads as coordinate (0,0).
    always_ff @(posedge clock) begin
        if (n_rst) begin
            for (int i = 0; i < DELAY; i++) begin
                v_pipe_r[i] <= '0;
                h_pipe_r[i] <= '0;
            end
        end else begin
            v_pipe_r[0] <= in_vcnt;
            h_pipe_r[0] <= in_hcnt;
            for (int i = 1; i < DELAY; i++) begin
                v_pipe_r[i] <= v_pipe_r[i-1];
                h_pipe_r[i] <= h_pipe_r[i-1];
            end
        end
    end

    assign out_vcnt = v_pipe_r[DELAY-1];
    assign out_hcnt = h_pipe_r[DELAY-1];

endmodule

// File: rtl/unpool_expand_line_buf.sv
// Half-width line buffer holding one block row of pooled values; one write port, one registered read port.
module unpool_line_buf #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              n_rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read, zero when disabled. Write-first: the top-left pixel of a block is read
    // on the very edge that stores the block value, so that value must be forwarded.
    always_ff @(posedge clock) begin
        if (n_rst) begin
            rd_data_r <= '0;
        end else if (!rd_en) begin
            rd_data_r <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_r <= wr_data;
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/unpool_expand.sv
// Nearest-neighbour 2x unpooling: each pooled value at odd/odd coordinates is replicated
// over its 2x2 block, with the frame counters delayed to match.
module unpool_expand
    import unpool_expand_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 4,
    parameter int W_WIDTH    = 12,
    parameter int W_HEIGHT   = 6,
    parameter int FIXED_BITW = 16,
    parameter int UNITS      = 2
) (
    input  logic                          clock,
    input  logic                          n_rst,
    input  logic [FIXED_BITW*UNITS-1:0]   in_pixels,
    input  logic [v_bitw_of(W_HEIGHT)-1:0] in_vcnt,
    input  logic [h_bitw_of(W_WIDTH)-1:0]  in_hcnt,
    output logic [FIXED_BITW*UNITS-1:0]   out_pixels,
    output logic [v_bitw_of(W_HEIGHT)-1:0] out_vcnt,
    output logic [h_bitw_of(W_WIDTH)-1:0]  out_hcnt
);

    localparam int V_BITW  = v_bitw_of(W_HEIGHT);
    localparam int H_BITW  = h_bitw_of(W_WIDTH);
    localparam int DATA_W  = FIXED_BITW * UNITS;
    localparam int DEPTH   = WIDTH / 2;
    localparam int ADDR_W  = log2(DEPTH);
    localparam int LATENCY = latency_of(W_WIDTH);

    localparam logic [V_BITW-1:0] HEIGHT_V = V_BITW'(HEIGHT);
    localparam logic [H_BITW-1:0] WIDTH_H  = H_BITW'(WIDTH);
    localparam logic [H_BITW-1:0] LAST_X   = H_BITW'(WIDTH - 1);

    logic              capture_s;
    logic              capture_last_s;
    logic              primed_next_s;
    logic              primed_r;
    logic              pre_active_s;
    logic              rd_en_s;
    logic [V_BITW-1:0] pre_vcnt_s;
    logic [H_BITW-1:0] pre_hcnt_s;
    logic [V_BITW-1:0] out_vcnt_r;
    logic [H_BITW-1:0] out_hcnt_r;
    logic [DATA_W-1:0] rd_data_s;

    // The counters are split one stage short so the buffer address is ready a cycle early.
    coord_adjuster #(
        .V_BITW (V_BITW),
        .H_BITW (H_BITW),
        .DELAY  (LATENCY - 1)
    ) u_coord (
        .clock    (clock),
        .n_rst    (n_rst),
        .in_vcnt  (in_vcnt),
        .in_hcnt  (in_hcnt),
        .out_vcnt (pre_vcnt_s),
        .out_hcnt (pre_hcnt_s)
    );

    // Capture decode, priming and read qualification.
    always_comb begin
        capture_s      = 1'b0;
        capture_last_s = 1'b0;
        pre_active_s   = 1'b0;
        if (in_vcnt[0] && in_hcnt[0] && (in_vcnt < HEIGHT_V) && (in_hcnt < WIDTH_H)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (capture_s && (in_hcnt == LAST_X)) begin
            capture_last_s = 1'b1;
        end else begin
            capture_last_s = 1'b0;
        end
        if ((pre_vcnt_s < HEIGHT_V) && (pre_hcnt_s < WIDTH_H)) begin
            pre_active_s = 1'b1;
        end else begin
            pre_active_s = 1'b0;
        end
        // The block row completes on this very edge, so its first output already counts as primed.
        primed_next_s = primed_r | capture_last_s;
        rd_en_s       = pre_active_s & primed_next_s;
    end

    // Primed flag and output counter stage.
    always_ff @(posedge clock) begin
        if (n_rst) begin
            primed_r   <= 1'b0;
            out_vcnt_r <= '0;
            out_hcnt_r <= '0;
        end else begin
            primed_r   <= primed_next_s;
            out_vcnt_r <= pre_vcnt_s;
            out_hcnt_r <= pre_hcnt_s;
        end
    end

    unpool_line_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_line_buf (
        .clock   (clock),
        .n_rst   (n_rst),
        .wr_en   (capture_s),
        .wr_addr (in_hcnt[ADDR_W:1]),
        .wr_data (in_pixels),
        .rd_en   (rd_en_s),
        .rd_addr (pre_hcnt_s[ADDR_W:1]),
        .rd_data (rd_data_s)
    );

    assign out_pixels = rd_data_s;
    assign out_vcnt   = out_vcnt_r;
    assign out_hcnt   = out_hcnt_r;

endmodule

// File: tb/tb_unpool_expand.sv
// Directed bench for unpool_expand: priming, replication, latency, blanking, mid-frame reset, extremes.
module tb_unpool_expand;

    localparam int WIDTH = 8, HEIGHT = 4, W_WIDTH = 12, W_HEIGHT = 6;
    localparam int LAT = 14;

    logic        clock = 1'b0;
    logic        n_rst = 1'b1;
    logic [31:0] in_pixels = 32'h0;
    logic [2:0]  in_vcnt = 3'd0;
    logic [3:0]  in_hcnt = 4'd0;
    logic [31:0] out_pixels;
    logic [2:0]  out_vcnt;
    logic [3:0]  out_hcnt;

    typedef struct { int v; int h; int mode; } coord_t;
    coord_t hist[$];

    int vectors = 0, miscompares = 0;
    int gy = 0, gx = 0, mode = 0, cyc_n = 0;
    int t_in = -1, t_out = -1;
    bit rst = 1'b1, primed_exp = 1'b0;

    unpool_expand #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .W_WIDTH(W_WIDTH), .W_HEIGHT(W_HEIGHT),
        .FIXED_BITW(16), .UNITS(2)
    ) dut (
        .clock(clock), .n_rst(n_rst), .in_pixels(in_pixels), .in_vcnt(in_vcnt),
        .in_hcnt(in_hcnt), .out_pixels(out_pixels), .out_vcnt(out_vcnt), .out_hcnt(out_hcnt)
    );

    always #5 clock = ~clock;

    // Pooled block value {ch1,ch0} for block (i,j) under each stimulus mode.
    function automatic logic [31:0] blockval(input int m, input int i, input int j);
        logic [15:0] c0;
        c0 = 16'(16 * i + j);
        if (m == 0) return {16'hF0F0 ^ c0, c0};
        else if (m == 1) return (i == 0 && j == 0) ? {16'h1234, 16'hABCD} : 32'h0;
        else return (((i + j) % 2) == 1) ? {16'h7FFF, 16'h8000} : {16'h8000, 16'h7FFF};
    endfunction

    task automatic cyc();
        bit cap;
        logic [15:0] g;
        cap = (gy % 2 == 1) && (gx % 2 == 1) && (gy < HEIGHT) && (gx < WIDTH);
        g = cyc_n[15:0];
        n_rst = rst;
        in_vcnt = 3'(gy);
        in_hcnt = 4'(gx);
        in_pixels = cap ? blockval(mode, gy / 2, gx / 2) : {16'hFFFF ^ g, 16'h5A5A ^ g};
        if (!rst && mode == 1 && gy == 0 && gx == 0 && t_in < 0) t_in = cyc_n;
        @(posedge clock);
        #1;
        if (rst) begin
            hist.delete();
            primed_exp = 1'b0;
        end else begin
            hist.push_back('{gy, gx, mode});
            if (hist.size() > LAT) void'(hist.pop_front());
            if (cap && gx == WIDTH - 1) primed_exp = 1'b1;
        end
        gx = gx + 1;
        if (gx == W_WIDTH) begin
            gx = 0;
            gy = (gy + 1) % W_HEIGHT;
        end
        cyc_n = cyc_n + 1;
    endtask

    task automatic check();
        logic [2:0]  ev;
        logic [3:0]  eh;
        logic [31:0] ep;
        bit do_pix;
        int em;
        em = 0;
        if (hist.size() == LAT) begin
            ev = 3'(hist[0].v);
            eh = 4'(hist[0].h);
            em = hist[0].mode;
        end else begin
            ev = 3'd0;
            eh = 4'd0;
        end
        do_pix = 1'b1;
        if (!primed_exp) ep = 32'h0;
        else if (hist.size() < LAT) begin ep = 32'h0; do_pix = 1'b0; end
        else if (ev < 3'(HEIGHT) && eh < 4'(WIDTH)) ep = blockval(em, int'(ev) / 2, int'(eh) / 2);
        else ep = 32'h0;
        vectors++;
        assert (out_vcnt === ev) else begin
            miscompares++;
            $error("FAIL out_vcnt cyc=%0d obs=%0d exp=%0d", cyc_n, out_vcnt, ev);
        end
        vectors++;
        assert (out_hcnt === eh) else begin
            miscompares++;
            $error("FAIL out_hcnt cyc=%0d obs=%0d exp=%0d", cyc_n, out_hcnt, eh);
        end
        if (do_pix) begin
            vectors++;
            assert (out_pixels === ep) else begin
                miscompares++;
                $error("FAIL out_pixels cyc=%0d at (%0d,%0d) obs=%h exp=%h", cyc_n, ev, eh, out_pixels, ep);
            end
        end
        if (t_out < 0 && t_in >= 0 && out_vcnt == 3'd0 && out_hcnt == 4'd0 && out_pixels == 32'h1234ABCD)
            t_out = cyc_n;
    endtask

    initial begin
        // Reset held with the counters mid-frame, then released at frame start.
        rst = 1'b1; gy = 3; gx = 5; mode = 0;
        repeat (3) begin cyc(); check(); end
        gy = 0; gx = 0; rst = 1'b0;
        // Two replication frames: priming in the first, steady state in the second.
        repeat (2 * W_WIDTH * W_HEIGHT) begin cyc(); check(); end
        // Single block value for the latency measurement.
        mode = 1;
        repeat (W_WIDTH * W_HEIGHT) begin cyc(); check(); end
        // Extreme values alternating by block.
        mode = 2;
        repeat (W_WIDTH * W_HEIGHT) begin cyc(); check(); end
        // Replication with a 3-cycle reset starting at input (2,6).
        mode = 0;
        repeat (30) begin cyc(); check(); end
        rst = 1'b1;
        repeat (3) begin cyc(); check(); end
        rst = 1'b0;
        repeat (W_WIDTH * W_HEIGHT - 33 + W_WIDTH * W_HEIGHT) begin cyc(); check(); end
        vectors++;
        assert (t_in >= 0 && t_out >= 0 && (t_out - t_in) == LAT) else begin
            miscompares++;
            $error("FAIL latency obs=%0d exp=%0d", t_out - t_in, LAT);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
